fp_mul_frontend: RTL
====================

# fp_mul_frontend

Operand-side sequencer and result packer for the sequential single-precision multiplier (`mainFP`-style core with `startFP`/`doneFP`). It accepts operand pairs on a valid/ready port and screens IEEE-754 special cases, bypassing the core for those. Otherwise it launches the core and holds its operands stable until completion. It then repairs exponent overflow/underflow, which the core wraps mod 256, and presents the packed result with exception flags on a valid/ready output port.

## Interface
- `TIMEOUT`, 64: max cycles spent in WAIT before abort; only used with `FPMUL_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: frontend accepts an operand pair.
- `in_a`, `in_b` in 32: IEEE-754 binary32 operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 32: packed binary32 product.
- `out_flags` out 4: {timeout, invalid, overflow, underflow}.
- `mul_start` out 1: drives the core `startFP`.
- `mul_a`, `mul_b` out 32: core operands, registered.
- `mul_done` in 1: core `doneFP` (high while the core is idle).
- `mul_result` in 32: core result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, START, WAIT, OUT. Reset state is IDLE.
- Reset values: `in_ready`=0 during reset, `out_valid`=0, `out_result`=0, `out_flags`=0, `mul_start`=0, `mul_a`=`mul_b`=0, `busy`=0. Timeout counter is 0.
- IDLE: `in_ready` = `mul_done`. On accept (`in_valid`&`in_ready`), latch `in_a`/`in_b` into `mul_a`/`mul_b` and classify. Exponent is E, fraction is F.
  - Either operand NaN (E=255, F≠0), or inf×zero: result 0x7FC00000, invalid=1 → OUT.
  - Either operand inf (and no NaN or zero): result {sa^sb, 8'hFF, 23'h0}, flags 0 → OUT.
  - Either operand E=0 (zero or denormal; flush-to-zero): result {sa^sb, 31'h0}, flags 0 → OUT.
  - Otherwise → START.
- START: `mul_start`=1 for exactly one cycle → WAIT.
- WAIT: `mul_start`=0. `mul_done` is ignored in the first WAIT cycle. On any later cycle with `mul_done`=1, pack the result → OUT.
- Packing, with Ea and Eb zero-extended to 10 bits:
  - base = Ea+Eb-127.
  - norm = (`mul_result[30:23]` ≠ base[7:0]).
  - Efull = base+norm, treated as signed.
  - Efull ≥ 255: {s, 8'hFF, 23'h0}, overflow=1.
  - Efull ≤ 0: {s, 31'h0}, underflow=1.
  - Otherwise: {s, Efull[7:0], `mul_result[22:0]`}.
  - s = sa^sb in every case; `mul_result[31]` is not used.
- Rounding is truncation, inherited from the core.
- OUT: `out_valid`=1. `out_result` and `out_flags` are held stable until `out_ready`=1. On that transfer the state returns to IDLE. There is no same-cycle accept of a new operand pair.
- `mul_a` and `mul_b` stay constant from accept until the next accept.
- Reset mid-operation: everything returns to reset values immediately. The core is reset by the same net, inverted at top level.

## Timing
- Bypass path: accept at cycle c0, `out_valid` at c1.
- Core path: accept at c0, `mul_start` at c1, WAIT from c2.
  - `out_valid` is asserted the cycle after the first qualifying `mul_done`=1 sample.
  - Latency is the core latency + 3.
- `in_ready` deasserts the cycle after accept. It reasserts the cycle after the output transfer, and only if `mul_done`=1.
- Back-pressure has no limit. The output is held indefinitely.

## Configuration
- `FPMUL_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `TIMEOUT` cycles elapse without a qualifying `mul_done`, go to OUT with result 0x7FC00000 and timeout=1.
  - IDLE still gates `in_ready` on `mul_done`, so a hung core blocks new work.
- `FPMUL_TIMEOUT_EN` undefined:
  - No counter is built, and `out_flags[3]` is tied to 0.
  - WAIT lasts until `mul_done` is seen, with no limit.

## Test plan
- Normal product: 0x40000000 × 0x40400000 → 0x40C00000, flags 0. `mul_start` pulses one cycle; `mul_a` and `mul_b` are stable throughout WAIT.
- Invalid bypass: 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1. `out_valid` at c1, `mul_start` never asserted.
- Overflow: 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1. Underflow: 0x80800000 × 0x00800000 → 0x80000000, underflow=1.
- Back-pressure: `out_ready`=0 for 10 cycles after `out_valid` → result and flags held, `in_ready`=0. A transfer then gives IDLE and `in_ready`=1 on the next cycle.
- Timeout (macro on, `TIMEOUT`=64): `mul_done` forced to 0 after start → `out_valid` with 0x7FC00000, flags 4'b1000, once 64 WAIT cycles have elapsed.
- Reset mid-WAIT: `rst`=0 pulse → `busy`, `out_valid` and `mul_start` go to 0 immediately. A subsequent normal operation completes correctly.

Source files
------------

// File: rtl/fp_mul_frontend.sv
// Operand sequencer and result packer for a sequential binary32 multiplier core.
// Define FPMUL_TIMEOUT_EN to build the WAIT-state watchdog (limit set by TIMEOUT).
module fp_mul_frontend #(
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_a,
    input  logic [31:0] i_in_b,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_result,
    output logic [3:0]  o_out_flags,
    output logic        o_mul_start,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    input  logic        i_mul_done,
    input  logic [31:0] i_mul_result,
    output logic        o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

    state_t             r_state, w_state_next;
    logic [31:0]        r_mul_a, r_mul_b;
    logic [31:0]        r_out_result, w_result_next;
    logic [2:0]         r_out_flags, w_flags_next;
    logic               r_wait_first, w_wait_first_next;
    logic               w_accept;

    // Operand screening on the incoming pair
    logic w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_nan, w_invalid, w_in_sign;
    assign w_inf_a   = (i_in_a[30:23] == 8'hFF) && (i_in_a[22:0] == 23'd0);
    assign w_inf_b   = (i_in_b[30:23] == 8'hFF) && (i_in_b[22:0] == 23'd0);
    assign w_zero_a  = (i_in_a[30:23] == 8'h00);
    assign w_zero_b  = (i_in_b[30:23] == 8'h00);
    assign w_nan     = ((i_in_a[30:23] == 8'hFF) && (i_in_a[22:0] != 23'd0)) ||
                       ((i_in_b[30:23] == 8'hFF) && (i_in_b[22:0] != 23'd0));
    assign w_invalid = w_nan || (w_inf_a && w_zero_b) || (w_inf_b && w_zero_a);
    assign w_in_sign = i_in_a[31] ^ i_in_b[31];

    // The core wraps its exponent mod 256; recover the true exponent from the
    // unwrapped sum and whether the core normalised by one position.
    logic [9:0]        w_base;
    logic              w_norm, w_sign;
    logic signed [9:0] w_efull;
    assign w_base  = {2'b00, r_mul_a[30:23]} + {2'b00, r_mul_b[30:23]} - 10'd127;
    assign w_norm  = (i_mul_result[30:23] != w_base[7:0]);
    assign w_efull = $signed(w_base + {9'd0, w_norm});
    assign w_sign  = r_mul_a[31] ^ r_mul_b[31];

    assign o_in_ready   = i_rst_n && (r_state == S_IDLE) && i_mul_done;
    assign w_accept     = i_in_valid && o_in_ready;
    assign o_out_valid  = (r_state == S_OUT);
    assign o_mul_start  = (r_state == S_START);
    assign o_busy       = (r_state != S_IDLE);
    assign o_mul_a      = r_mul_a;
    assign o_mul_b      = r_mul_b;
    assign o_out_result = r_out_result;

`ifdef FPMUL_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_timeout, w_timeout_next, w_expired;
    logic        w_unused;
    assign w_expired   = (r_cnt == 16'(TIMEOUT - 1));
    assign o_out_flags = {r_timeout, r_out_flags};
    assign w_unused    = i_mul_result[31];
`else
    logic w_unused;
    assign o_out_flags = {1'b0, r_out_flags};
    assign w_unused    = i_mul_result[31] ^ (TIMEOUT > 0);
`endif

    always_comb begin
        w_state_next      = r_state;
        w_result_next     = r_out_result;
        w_flags_next      = r_out_flags;
        w_wait_first_next = 1'b0;
`ifdef FPMUL_TIMEOUT_EN
        w_timeout_next    = r_timeout;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef FPMUL_TIMEOUT_EN
                    w_timeout_next = 1'b0;
`endif
                    w_flags_next = 3'b000;
                    if (w_invalid) begin
                        w_result_next = 32'h7FC0_0000;
                        w_flags_next  = 3'b100;
                        w_state_next  = S_OUT;
                    end else if (w_inf_a || w_inf_b) begin
                        w_result_next = {w_in_sign, 8'hFF, 23'd0};
                        w_state_next  = S_OUT;
                    end else if (w_zero_a || w_zero_b) begin
                        w_result_next = {w_in_sign, 31'd0};
                        w_state_next  = S_OUT;
                    end else begin
                        w_state_next  = S_START;
                    end
                end
            end
            S_START: begin
                w_state_next      = S_WAIT;
                w_wait_first_next = 1'b1;
            end
            S_WAIT: begin
                // The core's done is still stale in the first WAIT cycle.
                if (!r_wait_first && i_mul_done) begin
                    w_state_next = S_OUT;
                    if (w_efull >= 10'sd255) begin
                        w_result_next = {w_sign, 8'hFF, 23'd0};
                        w_flags_next  = 3'b010;
                    end else if (w_efull <= 10'sd0) begin
                        w_result_next = {w_sign, 31'd0};
                        w_flags_next  = 3'b001;
                    end else begin
                        w_result_next = {w_sign, w_efull[7:0], i_mul_result[22:0]};
                        w_flags_next  = 3'b000;
                    end
                end
`ifdef FPMUL_TIMEOUT_EN
                else if (w_expired) begin
                    w_state_next   = S_OUT;
                    w_result_next  = 32'h7FC0_0000;
                    w_flags_next   = 3'b000;
                    w_timeout_next = 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (i_out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_mul_a      <= 32'd0;
            r_mul_b      <= 32'd0;
            r_out_result <= 32'd0;
            r_out_flags  <= 3'd0;
            r_wait_first <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_out_result <= w_result_next;
            r_out_flags  <= w_flags_next;
            r_wait_first <= w_wait_first_next;
            if (w_accept) begin
                r_mul_a <= i_in_a;
                r_mul_b <= i_in_b;
            end
        end
    end

`ifdef FPMUL_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_next;
            if (r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
            else                   r_cnt <= 16'd0;
        end
    end
`endif

endmodule
